// File: rtl/systolic_feeder_pkg.sv
// ---------------------------------------------------------------------------
// systolic_feeder_pkg
// Shared definitions for the systolic array feeder: the FSM state type, the
// drain-length helper that sizes the FLUSH window, and the lane slice helper
// used to locate one element lane inside a packed slice bus.
// ---------------------------------------------------------------------------
package systolic_feeder_pkg;

  // Tile sequencing phases of the feeder.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FEED   = 2'd1,
    FLUSH  = 2'd2,
    STREAM = 2'd3
  } feeder_state_e;

  // Cycles needed after the last beat for the farthest PE (bottom-right corner)
  // to see its last operands and for the MAC pipeline to retire the final sum.
  function automatic int flush_len(input int rows, input int cols,
                                   input int mult_lat, input int add_lat);
    return rows + cols - 2 + mult_lat + add_lat + 1;
  endfunction

  // Low bit index of element lane 'lane' in a packed bus of 'width'-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// ---------------------------------------------------------------------------
// systolic_feeder_if
// Bundles the feeder's beat handshake, slice inputs and array-edge outputs.
//   master : tile producer (drives start/in_valid/a_slice/b_slice)
//   slave  : the feeder (drives in_ready, edge data, control pulses, status)
// Signals:
//   start, in_valid, in_ready      tile start and beat handshake
//   a_slice [ROWS*IN_WIDTH]        A column slice, lane r = A[r][k]
//   b_slice [COLS*IN_WIDTH]        B row slice,    lane c = B[k][c]
//   row_data_out / col_data_out    skewed west / north edge data
//   rst_accumulator_out            clears corner MAC accumulator
//   stream_out_rdy_out             starts psum drain at corner MAC
//   busy, tile_done                status
// ---------------------------------------------------------------------------
interface systolic_feeder_if #(
  parameter int IN_WIDTH = 8,
  parameter int ROWS     = 4,
  parameter int COLS     = 4
);

  logic                     start;
  logic                     in_valid;
  logic                     in_ready;
  logic [ROWS*IN_WIDTH-1:0] a_slice;
  logic [COLS*IN_WIDTH-1:0] b_slice;
  logic [ROWS*IN_WIDTH-1:0] row_data_out;
  logic [COLS*IN_WIDTH-1:0] col_data_out;
  logic                     rst_accumulator_out;
  logic                     stream_out_rdy_out;
  logic                     busy;
  logic                     tile_done;

  modport master (
    output start, in_valid, a_slice, b_slice,
    input  in_ready, row_data_out, col_data_out,
    input  rst_accumulator_out, stream_out_rdy_out, busy, tile_done
  );

  modport slave (
    input  start, in_valid, a_slice, b_slice,
    output in_ready, row_data_out, col_data_out,
    output rst_accumulator_out, stream_out_rdy_out, busy, tile_done
  );

endinterface

// File: rtl/systolic_feeder_skew_line.sv
// ---------------------------------------------------------------------------
// skew_line
// DEPTH-stage shift register for one edge lane; DEPTH = lane index + 1 gives
// the diagonal skew so each PE sees matching A/B operands on the same cycle.
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset, clears every stage
//   data_i  lane head value (already zero-muxed by the top)
//   data_o  value presented DEPTH cycles later
// ---------------------------------------------------------------------------
module skew_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift chain: stage 0 captures the head, later stages ripple forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
// Transmit side of the MAC array streaming protocol. Accepts K reduction beats
// per tile (A column slice + B row slice), drives the west/north array edges
// with diagonal skew, and sequences rst_accumulator / stream_out_rdy so every
// tile accumulates from zero and is drained exactly once.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset; aborts any tile in progress
//   bus    systolic_feeder_if.slave (handshake, slices, edge data, status)
// ---------------------------------------------------------------------------
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int K        = 4,
  parameter int MULT_LAT = 3,
  parameter int ADD_LAT  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  systolic_feeder_if.slave bus
);

  localparam int FLUSH_LEN = flush_len(ROWS, COLS, MULT_LAT, ADD_LAT);
  localparam int BEAT_W    = $clog2(K + 1);
  localparam int FLUSH_W   = $clog2(FLUSH_LEN + 1);
  localparam int STRM_W    = $clog2(COLS + 1);

  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(K - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_LEN - 1);
  localparam logic [STRM_W-1:0]  STRM_LAST  = STRM_W'(COLS - 1);

  feeder_state_e      state_q, state_d;
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [STRM_W-1:0]  strm_cnt_q, strm_cnt_d;
  logic               rst_acc_q, rst_acc_d;

  logic accept;
  logic in_ready;
  logic busy;
  logic stream_rdy;
  logic tile_done;

  logic [ROWS*IN_WIDTH-1:0] row_data;
  logic [COLS*IN_WIDTH-1:0] col_data;

  assign accept = bus.in_valid && (state_q == FEED);

  // State and counter registers; rst_acc sits in the same stage as lane 0 so
  // it lines up with beat 0 at the corner PE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      strm_cnt_q  <= '0;
      rst_acc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      strm_cnt_q  <= strm_cnt_d;
      rst_acc_q   <= rst_acc_d;
    end
  end

  // Next-state logic. Bubbles in FEED hold beat_cnt; start outside IDLE is dropped.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    strm_cnt_d  = strm_cnt_q;
    rst_acc_d   = accept && (beat_cnt_q == '0);
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = FEED;
          beat_cnt_d = '0;
        end
      end
      FEED: begin
        if (accept) begin
          if (beat_cnt_q == BEAT_LAST) begin
            state_d     = FLUSH;
            beat_cnt_d  = '0;
            flush_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = STREAM;
          flush_cnt_d = '0;
          strm_cnt_d  = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      STREAM: begin
        if (strm_cnt_q == STRM_LAST) begin
          state_d    = IDLE;
          strm_cnt_d = '0;
        end else begin
          strm_cnt_d = strm_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control outputs decoded from the current state. tile_done marks the last
  // STREAM cycle so busy drops on the following cycle.
  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    stream_rdy = 1'b0;
    tile_done  = 1'b0;
    in_ready   = (state_q == FEED);
    busy       = (state_q != IDLE);
    stream_rdy = (state_q == STREAM) && (strm_cnt_q == '0);
    tile_done  = (state_q == STREAM) && (strm_cnt_q == STRM_LAST);
  end

  // West edge: lane r head carries the accepted element or zero, skewed r+1.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [IN_WIDTH-1:0] head;
    assign head = accept ? bus.a_slice[lane_lo(r, IN_WIDTH) +: IN_WIDTH] : '0;
    skew_line #(.WIDTH(IN_WIDTH), .DEPTH(r + 1)) u_skew (
      .clk    (clk),
      .rst_n  (rst_n),
      .data_i (head),
      .data_o (row_data[lane_lo(r, IN_WIDTH) +: IN_WIDTH])
    );
  end

  // North edge: same scheme per column lane, skewed c+1.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [IN_WIDTH-1:0] head;
    assign head = accept ? bus.b_slice[lane_lo(c, IN_WIDTH) +: IN_WIDTH] : '0;
    skew_line #(.WIDTH(IN_WIDTH), .DEPTH(c + 1)) u_skew (
      .clk    (clk),
      .rst_n  (rst_n),
      .data_i (head),
      .data_o (col_data[lane_lo(c, IN_WIDTH) +: IN_WIDTH])
    );
  end

  assign bus.in_ready            = in_ready;
  assign bus.busy                = busy;
  assign bus.stream_out_rdy_out  = stream_rdy;
  assign bus.tile_done           = tile_done;
  assign bus.rst_accumulator_out = rst_acc_q;
  assign bus.row_data_out        = row_data;
  assign bus.col_data_out        = col_data;

endmodule
